// File: rtl/ej4_pkg.sv
// Shared constants and types for the ej4 three-function evaluator.
// Minterm masks are indexed by {A,B,C,D}, with A as the MSB.
package ej4_pkg;

    localparam logic [15:0] F_MINTERMS = 16'hA5A5;
    localparam logic [15:0] G_MINTERMS = 16'hE8E8;
    localparam logic [15:0] H_MINTERMS = 16'h6996;

    typedef struct packed {
        logic f;
        logic g;
        logic h;
    } fgh_t;

    function automatic logic mask_bit(input logic [15:0] mask, input logic [3:0] idx);
        return mask[idx];
    endfunction

endpackage

// File: rtl/ej4_if.sv
// Operand bits and registered results of ej4, grouped for connection.
// The bench drives through master; the design uses slave.
interface ej4_if;

    logic A;
    logic B;
    logic C;
    logic D;
    logic f;
    logic g;
    logic h;
    logic fb;
    logic gb;
    logic hb;
    logic mismatch;

    modport master (
        output A, B, C, D,
        input  f, g, h, fb, gb, hb, mismatch
    );

    modport slave (
        input  A, B, C, D,
        output f, g, h, fb, gb, hb, mismatch
    );

endinterface

// File: rtl/ej4_logic.sv
// Purely combinational evaluation of f/g/h in two forms: a minterm-table
// lookup and the hand-minimised Boolean expressions.
module ej4_logic
    import ej4_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    input  logic d_i,
    output fgh_t can_o,
    output fgh_t min_o
);

    logic [3:0] idx_s;

    // Table lookup and minimised forms computed side by side.
    always_comb begin
        idx_s   = {a_i, b_i, c_i, d_i};
        can_o.f = mask_bit(F_MINTERMS, idx_s);
        can_o.g = mask_bit(G_MINTERMS, idx_s);
        can_o.h = mask_bit(H_MINTERMS, idx_s);
        min_o.f = ~(b_i ^ d_i);
        min_o.g = (b_i & c_i) | (b_i & d_i) | (c_i & d_i);
        min_o.h = a_i ^ b_i ^ c_i ^ d_i;
    end

endmodule

// File: rtl/ej4.sv
// ej4 top: registers both evaluation paths and flags any disagreement
// between them, one clock after the operands are sampled.
module ej4
    import ej4_pkg::*;
(
    input  logic clk,
    input  logic reset,
    ej4_if.slave bus
);

    fgh_t can_s;
    fgh_t min_s;
    fgh_t can_d;
    fgh_t min_d;
    fgh_t can_q;
    fgh_t min_q;
    logic mism_d;
    logic mism_q;

    ej4_logic u_logic (
        .a_i   (bus.A),
        .b_i   (bus.B),
        .c_i   (bus.C),
        .d_i   (bus.D),
        .can_o (can_s),
        .min_o (min_s)
    );

    // Next state: this cycle's results and their cross-check.
    always_comb begin
        can_d  = can_s;
        min_d  = min_s;
        mism_d = |(can_s ^ min_s);
    end

    // Output registers; reset wins over sampling and drops the in-flight sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            can_q  <= '0;
            min_q  <= '0;
            mism_q <= 1'b0;
        end else begin
            can_q  <= can_d;
            min_q  <= min_d;
            mism_q <= mism_d;
        end
    end

    assign bus.f        = can_q.f;
    assign bus.g        = can_q.g;
    assign bus.h        = can_q.h;
    assign bus.fb       = min_q.f;
    assign bus.gb       = min_q.g;
    assign bus.hb       = min_q.h;
    assign bus.mismatch = mism_q;

endmodule

// File: tb/tb_ej4.sv
// Self-checking bench for ej4: directed reset/sweep/corner steps, then
// random back-to-back operands checked against a minterm-list model.
module tb_ej4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    ej4_if bus_if ();

    ej4 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: membership of idx in each function's minterm list.
    function automatic logic [2:0] model_fgh(input int idx);
        logic f, g, h;
        f = (idx inside {0, 2, 5, 7, 8, 10, 13, 15});
        g = (idx inside {3, 5, 6, 7, 11, 13, 14, 15});
        h = (idx inside {1, 2, 4, 7, 8, 11, 13, 14});
        return {f, g, h};
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] exp_fgh);
        check1({tag, ".f"},  bus_if.f,        exp_fgh[2]);
        check1({tag, ".g"},  bus_if.g,        exp_fgh[1]);
        check1({tag, ".h"},  bus_if.h,        exp_fgh[0]);
        check1({tag, ".fb"}, bus_if.fb,       exp_fgh[2]);
        check1({tag, ".gb"}, bus_if.gb,       exp_fgh[1]);
        check1({tag, ".hb"}, bus_if.hb,       exp_fgh[0]);
        check1({tag, ".mm"}, bus_if.mismatch, 1'b0);
    endtask

    // Drive operands and reset at negedge, let one rising edge pass, sample at next negedge.
    task automatic step(input logic [3:0] idx, input logic rst);
        {bus_if.A, bus_if.B, bus_if.C, bus_if.D} = idx;
        reset = rst;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] ridx;
        logic       rrst;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        {bus_if.A, bus_if.B, bus_if.C, bus_if.D} = 4'd15;
        @(negedge clk);

        step(4'd15, 1'b1);
        check_all("reset_idx15", 3'b000);

        for (int i = 0; i < 16; i++) begin
            step(4'(i), 1'b0);
            check_all($sformatf("sweep%0d", i), model_fgh(i));
        end

        step(4'd0, 1'b0);
        check_all("idx0", 3'b100);
        step(4'd7, 1'b0);
        check_all("idx7", 3'b111);
        step(4'd9, 1'b0);
        check_all("idx9", 3'b000);
        step(4'd14, 1'b0);
        check_all("idx14", 3'b011);

        // idx=7 presented on the same edge reset is asserted must never appear.
        step(4'd7, 1'b1);
        check_all("rst_over_idx7", 3'b000);
        step(4'd9, 1'b0);
        check_all("after_rst_idx9", 3'b000);
        step(4'd2, 1'b0);
        check_all("after_rst_idx2", model_fgh(2));

        for (int i = 0; i < 200; i++) begin
            ridx = 4'($urandom_range(15, 0));
            rrst = ($urandom_range(31, 0) == 0);
            step(ridx, rrst);
            check_all($sformatf("rand%0d", i), rrst ? 3'b000 : model_fgh(int'(ridx)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
